pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter block for the MIPS datapath fetch stage.
- Merges the PC register and the PC+INC adder into one unit.
- Adds next-PC selection (sequential, branch, jump, register jump, exception), stall hold, a reset warm-up state, misaligned-target trapping and a saturating fetch counter.
- Feeds the instruction-memory address and the IF/ID PC+INC field.

Parameters:
- WIDTH, 32, address/data width of PC; minimum 8.
- INC, 4, sequential increment in bytes; power of two.
- RESET_VECTOR, 0, PC value loaded by reset.
- EXC_VECTOR, 32'h00000080, PC loaded on Exception or misaligned-target trap.
- CNT_W, 32, width of the fetch counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold PC (hazard unit).
- Exception  input  1  redirect to EXC_VECTOR.
- BranchTaken  input  1  take PC-relative branch.
- BranchOffset  input  WIDTH  sign-extended word offset.
- JumpEn  input  1  take pseudo-direct jump.
- JumpIndex  input  WIDTH-6  jump word index.
- JumpReg  input  1  take register jump.
- RegTarget  input  WIDTH  register jump byte address.
- PCResult  output  WIDTH  current PC (registered).
- PCAddResult  output  WIDTH  PCResult+INC (combinational, mod 2^WIDTH).
- PCValid  output  1  PCResult is a real fetch address.
- Fault  output  1  one-cycle pulse: misaligned target trapped.
- FetchCount  output  CNT_W  number of PC advances since reset.

Behaviour:
- All state updates on rising Clk edge; no combinational path from inputs to PCResult.
- Reset (dominates all inputs, including mid-redirect or mid-stall) sets:
  - PCResult=RESET_VECTOR, PCValid=0, Fault=0, FetchCount=0, state=WARMUP.
- FSM, 2 states:
  - WARMUP: one cycle, inputs ignored, PC held. Next edge -> RUN, PCValid=1.
  - RUN: remains until Reset; PCValid=1.
- Next-PC in RUN, strict priority:
  1. Exception -> EXC_VECTOR; overrides Stall.
  2. Stall -> hold PCResult; FetchCount unchanged; Fault=0.
  3. JumpReg -> RegTarget.
  4. JumpEn -> {PCAddResult[WIDTH-1:WIDTH-4], JumpIndex, 2'b00}.
  5. BranchTaken -> PCAddResult + (BranchOffset<<2).
  6. Otherwise -> PCAddResult.
- Arithmetic: modulo 2^WIDTH; wrap-around from max address to 0 is legal and silent.
- Misaligned trap:
  - Applies when the selected target from 3–5 has bits [log2(INC)-1:0] != 0.
  - PC loads EXC_VECTOR instead; Fault=1 for exactly that following cycle.
  - Sequential and exception targets are never checked.
- FetchCount:
  - Increments by 1 on every RUN edge where PC is not held by Stall, including redirects and traps.
  - Saturates at all-ones.
- Simultaneous requests resolve by priority only; lower-priority requests are dropped, not queued.

Test Plan:
- Reset held 2 cycles then released -> PCResult=0, PCValid=0 for one cycle after release, then PCResult=0,4,8,C on successive edges; FetchCount=0,1,2,3.
- PC=0x10, Stall=1 for 3 cycles -> PCResult stays 0x10, FetchCount constant; Stall with Exception=1 -> PCResult=0x80 next edge.
- PC=0x10, BranchTaken=1, BranchOffset=-2 (0xFFFFFFFE) -> PCResult=0x0C; same cycle JumpEn=1, JumpIndex=0x40 -> PCResult=0x100 (jump wins).
- PC=0x20, JumpReg=1, RegTarget=0x1002 -> PCResult=0x80, Fault=1 for exactly one cycle; RegTarget=0x1000 -> PCResult=0x1000, Fault=0.
- PC=0xFFFFFFFC, no requests -> PCResult=0x00000000, PCAddResult=0x4; Reset asserted during BranchTaken -> PCResult=RESET_VECTOR, FetchCount=0.
- CNT_W=3 instance run 10 cycles unstalled -> FetchCount saturates at 7.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-stage program counter for the MIPS datapath. It holds the PC register
// and its PC+INC adder, and chooses the next PC from these sources:
// sequential, branch, pseudo-direct jump, register jump or exception.
// It also provides a stall hold, a one-cycle warm-up state after reset,
// trapping of misaligned redirect targets, and a saturating fetch counter.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   Stall        in   hold the PC (hazard unit)
//   Exception    in   redirect to EXC_VECTOR (overrides Stall)
//   BranchTaken  in   take the PC-relative branch
//   BranchOffset in   sign-extended word offset [WIDTH]
//   JumpEn       in   take the pseudo-direct jump
//   JumpIndex    in   jump word index [WIDTH-6]
//   JumpReg      in   take the register jump
//   RegTarget    in   register jump byte address [WIDTH]
//   PCResult     out  current PC (registered) [WIDTH]
//   PCAddResult  out  PCResult + INC, modulo 2^WIDTH [WIDTH]
//   PCValid      out  PCResult is a real fetch address
//   Fault        out  one-cycle pulse after a misaligned target is trapped
//   FetchCount   out  saturating count of PC advances since reset [CNT_W]
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       INC          = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h00000080),
    parameter int unsigned       CNT_W        = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 Exception,
    input  logic                 BranchTaken,
    input  logic [WIDTH-1:0]     BranchOffset,
    input  logic                 JumpEn,
    input  logic [WIDTH-7:0]     JumpIndex,
    input  logic                 JumpReg,
    input  logic [WIDTH-1:0]     RegTarget,
    output logic [WIDTH-1:0]     PCResult,
    output logic [WIDTH-1:0]     PCAddResult,
    output logic                 PCValid,
    output logic                 Fault,
    output logic [CNT_W-1:0]     FetchCount
);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    // The low log2(INC) address bits must be zero. Because INC is a power of
    // two, INC-1 is exactly the mask of those bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [0:0]              state_q, state_d;
    logic [WIDTH-1:0]        pc_q, pc_d;
    logic                    fault_q, fault_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [WIDTH-1:0]        pc_add;
    logic signed [WIDTH-1:0] br_off_s;
    logic signed [WIDTH-1:0] br_disp_s;
    logic [WIDTH-1:0]        br_target;
    logic [WIDTH-1:0]        jmp_target;
    logic [WIDTH-1:0]        redir_tgt;
    logic                    redir_chk;

    assign pc_add     = pc_q + WIDTH'(INC);
    assign br_off_s   = signed'(BranchOffset);
    assign br_disp_s  = br_off_s <<< 2;
    assign br_target  = pc_add + $unsigned(br_disp_s);
    assign jmp_target = {pc_add[WIDTH-1:WIDTH-4], JumpIndex, 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = 1'b0;
        cnt_d     = cnt_q;
        redir_tgt = pc_add;
        redir_chk = 1'b0;

        case (state_q)
            ST_WARMUP: begin
                // Warm-up ignores every request and keeps the reset vector.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Exception) begin
                    pc_d  = EXC_VECTOR;
                    cnt_d = sat_inc(cnt_q);
                end else if (!Stall) begin
                    cnt_d = sat_inc(cnt_q);
                    if (JumpReg) begin
                        redir_tgt = RegTarget;
                        redir_chk = 1'b1;
                    end else if (JumpEn) begin
                        redir_tgt = jmp_target;
                        redir_chk = 1'b1;
                    end else if (BranchTaken) begin
                        redir_tgt = br_target;
                        redir_chk = 1'b1;
                    end
                    // Only redirect targets can be misaligned. The sequential
                    // path is aligned by construction.
                    if (redir_chk && ((redir_tgt & ALIGN_MASK) != '0)) begin
                        pc_d    = EXC_VECTOR;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end
            end
            default: state_d = ST_WARMUP;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_WARMUP;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCResult    = pc_q;
    assign PCAddResult = pc_add;
    assign PCValid     = (state_q == ST_RUN);
    assign Fault       = fault_q;
    assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Exception, BranchTaken, JumpEn, JumpReg;
    logic [31:0] BranchOffset, RegTarget;
    logic [25:0] JumpIndex;
    logic [31:0] PCResult, PCAddResult;
    logic        PCValid, Fault;
    logic [31:0] FetchCount;

    logic        Reset2;
    logic [31:0] PCResult2, PCAddResult2;
    logic        PCValid2, Fault2;
    logic [2:0]  FetchCount2;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt;

    always #5 Clk = ~Clk;

    pc_sequencer #(.WIDTH(32), .INC(4), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Exception(Exception),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .JumpEn(JumpEn), .JumpIndex(JumpIndex), .JumpReg(JumpReg),
        .RegTarget(RegTarget), .PCResult(PCResult), .PCAddResult(PCAddResult),
        .PCValid(PCValid), .Fault(Fault), .FetchCount(FetchCount)
    );

    pc_sequencer #(.WIDTH(32), .INC(4), .CNT_W(3)) dut_sat (
        .Clk(Clk), .Reset(Reset2), .Stall(1'b0), .Exception(1'b0),
        .BranchTaken(1'b0), .BranchOffset(32'h0),
        .JumpEn(1'b0), .JumpIndex(26'h0), .JumpReg(1'b0),
        .RegTarget(32'h0), .PCResult(PCResult2), .PCAddResult(PCAddResult2),
        .PCValid(PCValid2), .Fault(Fault2), .FetchCount(FetchCount2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_req();
        Stall = 1'b0; Exception = 1'b0; BranchTaken = 1'b0; JumpEn = 1'b0;
        JumpReg = 1'b0; BranchOffset = '0; JumpIndex = '0; RegTarget = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        clear_req();
        tick(); tick();
        total++; if (PCResult !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PCResult, 32'h0); end
        total++; if (PCValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", PCValid); end
        total++; if (Fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", Fault); end
        total++; if (FetchCount !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", FetchCount); end
        Reset = 1'b0;
        // Warm-up: requests present now must be ignored.
        BranchTaken = 1'b1; BranchOffset = 32'h10;
        #1;
        total++; if (PCValid !== 1'b0) begin bad++; $display("FAIL warmup_valid got=%b exp=0", PCValid); end
        tick();
        clear_req();
        total++; if (PCValid !== 1'b1) begin bad++; $display("FAIL run_valid got=%b exp=1", PCValid); end
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            total++; if (PCResult !== 32'(i * 4)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, PCResult, 32'(i * 4)); end
            total++; if (PCAddResult !== 32'(i * 4 + 4)) begin bad++; $display("FAIL seq_add[%0d] got=%h exp=%h", i, PCAddResult, 32'(i * 4 + 4)); end
            total++; if (FetchCount !== exp_cnt) begin bad++; $display("FAIL seq_cnt[%0d] got=%0d exp=%0d", i, FetchCount, exp_cnt); end
            if (i < 4) begin tick(); exp_cnt++; end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (PCResult !== 32'h10) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, PCResult, 32'h10); end
            total++; if (FetchCount !== exp_cnt) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", i, FetchCount, exp_cnt); end
        end
        Exception = 1'b1;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h80) begin bad++; $display("FAIL stall_exc_pc got=%h exp=%h", PCResult, 32'h80); end
        total++; if (FetchCount !== exp_cnt) begin bad++; $display("FAIL stall_exc_cnt got=%0d exp=%0d", FetchCount, exp_cnt); end
    endtask

    task automatic test_branch_jump();
        JumpReg = 1'b1; RegTarget = 32'h10;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h10) begin bad++; $display("FAIL jr_setup got=%h exp=%h", PCResult, 32'h10); end
        BranchTaken = 1'b1; BranchOffset = 32'hFFFFFFFE;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h0C) begin bad++; $display("FAIL branch_back got=%h exp=%h", PCResult, 32'h0C); end
        tick(); exp_cnt++;
        BranchTaken = 1'b1; BranchOffset = 32'hFFFFFFFE; JumpEn = 1'b1; JumpIndex = 26'h40;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h100) begin bad++; $display("FAIL jump_wins got=%h exp=%h", PCResult, 32'h100); end
        total++; if (FetchCount !== exp_cnt) begin bad++; $display("FAIL jump_cnt got=%0d exp=%0d", FetchCount, exp_cnt); end
    endtask

    task automatic test_trap();
        JumpReg = 1'b1; RegTarget = 32'h20;
        tick(); exp_cnt++;
        RegTarget = 32'h1002;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h80) begin bad++; $display("FAIL trap_pc got=%h exp=%h", PCResult, 32'h80); end
        total++; if (Fault !== 1'b1) begin bad++; $display("FAIL trap_fault got=%b exp=1", Fault); end
        total++; if (FetchCount !== exp_cnt) begin bad++; $display("FAIL trap_cnt got=%0d exp=%0d", FetchCount, exp_cnt); end
        tick(); exp_cnt++;
        total++; if (Fault !== 1'b0) begin bad++; $display("FAIL trap_pulse got=%b exp=0", Fault); end
        total++; if (PCResult !== 32'h84) begin bad++; $display("FAIL after_trap_pc got=%h exp=%h", PCResult, 32'h84); end
        JumpReg = 1'b1; RegTarget = 32'h1000;
        tick(); exp_cnt++;
        clear_req();
        total++; if (PCResult !== 32'h1000) begin bad++; $display("FAIL jr_aligned got=%h exp=%h", PCResult, 32'h1000); end
        total++; if (Fault !== 1'b0) begin bad++; $display("FAIL jr_aligned_fault got=%b exp=0", Fault); end
    endtask

    task automatic test_wrap_reset();
        JumpReg = 1'b1; RegTarget = 32'hFFFFFFFC;
        tick();
        clear_req();
        total++; if (PCAddResult !== 32'h0) begin bad++; $display("FAIL wrap_add_top got=%h exp=%h", PCAddResult, 32'h0); end
        tick();
        total++; if (PCResult !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", PCResult, 32'h0); end
        total++; if (PCAddResult !== 32'h4) begin bad++; $display("FAIL wrap_add got=%h exp=%h", PCAddResult, 32'h4); end
        tick();
        BranchTaken = 1'b1; BranchOffset = 32'h5; Stall = 1'b1; Exception = 1'b1; Reset = 1'b1;
        tick();
        total++; if (PCResult !== 32'h0) begin bad++; $display("FAIL rst_mid_pc got=%h exp=%h", PCResult, 32'h0); end
        total++; if (FetchCount !== 32'h0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", FetchCount); end
        total++; if (PCValid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", PCValid); end
        Reset = 1'b0;
        clear_req();
    endtask

    task automatic test_saturate();
        Reset2 = 1'b1;
        tick();
        Reset2 = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (FetchCount2 !== 3'((i > 7) ? 7 : i)) begin
                bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, FetchCount2, (i > 7) ? 7 : i);
            end
            tick();
        end
        total++; if (FetchCount2 !== 3'd7) begin bad++; $display("FAIL sat_final got=%0d exp=7", FetchCount2); end
    endtask

    initial begin
        Reset2 = 1'b1;
        exp_cnt = 0;
        test_reset();
        test_stall();
        test_branch_jump();
        test_trap();
        test_wrap_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
